// File: rtl/midi_msg_sequencer.sv
// midi_msg_sequencer
// Assembles the deserializer's MIDI byte stream into complete channel-voice messages.
// Handles running status, SysEx skipping and interleaved real-time bytes. Note-on with
// velocity 0 is rewritten as note-off. Each message is presented through a one-entry
// valid/ready output buffer.
//
// Ports:
//   clock       system clock
//   reset       synchronous, active-high reset
//   byte_valid  one-cycle strobe marking a received byte
//   byte_data   received byte
//   msg_valid   output buffer holds a message
//   msg_ready   consumer accepts the message when msg_valid && msg_ready
//   msg_status  {type[3:0], channel[3:0]}
//   msg_data1   first data byte
//   msg_data2   second data byte, 0 for one-data-byte messages
//   drop_count  messages lost to a full buffer, saturating at 255
module midi_msg_sequencer #(
    parameter int unsigned CHAN_FILTER_EN = 0,
    parameter logic [3:0]  CHAN           = 4'd0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       msg_valid,
    input  logic       msg_ready,
    output logic [7:0] msg_status,
    output logic [6:0] msg_data1,
    output logic [6:0] msg_data2,
    output logic [7:0] drop_count
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WAIT_D1 = 2'd1;
    localparam logic [1:0] WAIT_D2 = 2'd2;
    localparam logic [1:0] SYSEX   = 2'd3;

    logic [1:0] state_q, state_d;
    logic [7:0] run_status_q, run_status_d;
    logic       rs_valid_q, rs_valid_d;
    logic [6:0] d1_q, d1_d;

    logic       is_data, is_chan, is_sys;
    logic       one_byte;
    logic       done;
    logic [6:0] done_d1, done_d2;
    logic [3:0] done_type;
    logic       chan_ok;
    logic       emit;
    logic       accept;

    // Real-time bytes (0xF8-0xFF) fall in none of these classes and are ignored.
    assign is_data  = ~byte_data[7];
    assign is_chan  = byte_data[7] && (byte_data[7:4] != 4'hF);
    assign is_sys   = (byte_data[7:4] == 4'hF) && ~byte_data[3];
    // Program change (0xC) and channel pressure (0xD) carry a single data byte.
    assign one_byte = (run_status_q[7:5] == 3'b110);

    always_comb begin
        state_d      = state_q;
        run_status_d = run_status_q;
        rs_valid_d   = rs_valid_q;
        d1_d         = d1_q;
        done         = 1'b0;
        done_d1      = byte_data[6:0];
        done_d2      = 7'd0;
        if (byte_valid) begin
            if (is_chan) begin
                run_status_d = byte_data;
                rs_valid_d   = 1'b1;
                state_d      = WAIT_D1;
            end else if (is_sys) begin
                rs_valid_d = 1'b0;
                state_d    = (byte_data == 8'hF0) ? SYSEX : IDLE;
            end else if (is_data && rs_valid_q) begin
                case (state_q)
                    WAIT_D1: begin
                        if (one_byte) begin
                            done = 1'b1;
                        end else begin
                            d1_d    = byte_data[6:0];
                            state_d = WAIT_D2;
                        end
                    end
                    WAIT_D2: begin
                        done    = 1'b1;
                        done_d1 = d1_q;
                        done_d2 = byte_data[6:0];
                        state_d = WAIT_D1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        done_type = run_status_q[7:4];
        if (done_type == 4'h9 && done_d2 == 7'd0) begin
            done_type = 4'h8;
        end
    end

    assign chan_ok = (CHAN_FILTER_EN == 0) || (run_status_q[3:0] == CHAN);
    assign emit    = done && chan_ok;
    assign accept  = msg_valid && msg_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            run_status_q <= 8'd0;
            rs_valid_q   <= 1'b0;
            d1_q         <= 7'd0;
            msg_valid    <= 1'b0;
            msg_status   <= 8'd0;
            msg_data1    <= 7'd0;
            msg_data2    <= 7'd0;
            drop_count   <= 8'd0;
        end else begin
            state_q      <= state_d;
            run_status_q <= run_status_d;
            rs_valid_q   <= rs_valid_d;
            d1_q         <= d1_d;
            if (emit) begin
                // A buffer being drained this cycle can take the new message directly.
                if (!msg_valid || accept) begin
                    msg_valid  <= 1'b1;
                    msg_status <= {done_type, run_status_q[3:0]};
                    msg_data1  <= done_d1;
                    msg_data2  <= done_d2;
                end else if (drop_count != 8'hFF) begin
                    drop_count <= drop_count + 8'd1;
                end
            end else if (accept) begin
                msg_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_midi_msg_sequencer.sv
// Scoreboard bench for midi_msg_sequencer: an unfiltered instance and a channel-3
// filtered instance share the same stimulus. A message-level reference model pushes
// expected messages into per-instance queues; a negedge monitor pops and compares.
module tb_midi_msg_sequencer;

    logic       clock;
    logic       reset;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       msg_ready;

    logic       v0, v1;
    logic [7:0] s0, s1;
    logic [6:0] a0, a1, b0, b1;
    logic [7:0] dc0, dc1;

    midi_msg_sequencer #(
        .CHAN_FILTER_EN(0),
        .CHAN          (4'd0)
    ) dut0 (
        .clock     (clock),
        .reset     (reset),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .msg_valid (v0),
        .msg_ready (msg_ready),
        .msg_status(s0),
        .msg_data1 (a0),
        .msg_data2 (b0),
        .drop_count(dc0)
    );

    midi_msg_sequencer #(
        .CHAN_FILTER_EN(1),
        .CHAN          (4'd3)
    ) dut1 (
        .clock     (clock),
        .reset     (reset),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .msg_valid (v1),
        .msg_ready (msg_ready),
        .msg_status(s1),
        .msg_data1 (a1),
        .msg_data2 (b1),
        .drop_count(dc1)
    );

    always #10 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model state, index 0 = unfiltered, 1 = channel-3 filter.
    bit         have_st [2];
    logic [7:0] st      [2];
    logic [6:0] pend    [2][2];
    int         pend_n  [2];
    bit         exp_full[2];
    int         exp_drop[2];
    logic [21:0] q0[$];
    logic [21:0] q1[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Message-level view: a status opens a message of known length, data bytes fill it.
    task automatic model_byte(input int m, input logic [7:0] b, output bit emit,
                              output logic [21:0] msg);
        int need;
        logic [3:0] typ;
        logic [6:0] d2;
        emit = 0;
        msg  = 22'd0;
        if (b >= 8'hF8) begin
            // real-time: transparent
        end else if (b < 8'h80) begin
            if (have_st[m]) begin
                need = (st[m][7:4] == 4'hC || st[m][7:4] == 4'hD) ? 1 : 2;
                pend[m][pend_n[m]] = b[6:0];
                pend_n[m]++;
                if (pend_n[m] == need) begin
                    pend_n[m] = 0;
                    typ = st[m][7:4];
                    d2  = (need == 2) ? pend[m][1] : 7'd0;
                    if (typ == 4'h9 && d2 == 7'd0) typ = 4'h8;
                    msg = {typ, st[m][3:0], pend[m][0], d2};
                    emit = (m == 0) || (st[m][3:0] == 4'd3);
                end
            end
        end else if (b < 8'hF0) begin
            have_st[m] = 1;
            st[m]      = b;
            pend_n[m]  = 0;
        end else begin
            have_st[m] = 0;
            pend_n[m]  = 0;
        end
    endtask

    // Applies what the DUTs see on this clock edge to the model.
    task automatic model_edge();
        bit emit;
        bit acc;
        logic [21:0] msg;
        if (reset) begin
            for (int m = 0; m < 2; m++) begin
                have_st[m]  = 0;
                pend_n[m]   = 0;
                exp_full[m] = 0;
                exp_drop[m] = 0;
            end
            q0.delete();
            q1.delete();
        end else begin
            for (int m = 0; m < 2; m++) begin
                emit = 0;
                if (byte_valid) model_byte(m, byte_data, emit, msg);
                acc = exp_full[m] && msg_ready;
                if (emit) begin
                    if (!exp_full[m] || acc) begin
                        if (m == 0) q0.push_back(msg);
                        else q1.push_back(msg);
                        exp_full[m] = 1;
                    end else if (exp_drop[m] < 255) begin
                        exp_drop[m]++;
                    end
                end else if (acc) begin
                    exp_full[m] = 0;
                end
            end
        end
    endtask

    task automatic step(input logic rst, input logic v, input logic [7:0] b, input logic r);
        @(posedge clock);
        model_edge();
        #1;
        reset      = rst;
        byte_valid = v;
        byte_data  = b;
        msg_ready  = r;
    endtask

    task automatic send(input logic [7:0] b, input logic r);
        step(1'b0, 1'b1, b, r);
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, r);
    endtask

    task automatic mon(input int m, input logic v, input logic [7:0] s, input logic [6:0] a,
                       input logic [6:0] b, input logic [7:0] dc);
        logic [21:0] front;
        int qs;
        check($sformatf("valid%0d", m), 32'(v), 32'(exp_full[m]));
        check($sformatf("drop%0d", m), 32'(dc), 32'(exp_drop[m]));
        if (v === 1'b1) begin
            qs = (m == 0) ? q0.size() : q1.size();
            total++;
            if (qs == 0) begin
                bad++;
                $display("FAIL msg%0d: got %h_%h_%h, expected no message", m, s, a, b);
            end else begin
                front = (m == 0) ? q0[0] : q1[0];
                if ({s, a, b} !== front) begin
                    bad++;
                    $display("FAIL msg%0d: got %h, expected %h", m, {s, a, b}, front);
                end
                if (msg_ready) begin
                    if (m == 0) void'(q0.pop_front());
                    else void'(q1.pop_front());
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clock);
            mon(0, v0, s0, a0, b0, dc0);
            mon(1, v1, s1, a1, b1, dc1);
        end
    end

    function automatic logic [7:0] rand_byte();
        int r;
        r = $urandom_range(0, 99);
        if (r < 12) return 8'h00;
        if (r < 55) return 8'($urandom_range(1, 127));
        if (r < 80) begin
            if ($urandom_range(0, 1) == 1) return {4'($urandom_range(8, 14)), 4'd3};
            return 8'($urandom_range(8'h80, 8'hEF));
        end
        if (r < 88) return 8'($urandom_range(8'hF0, 8'hF7));
        return 8'($urandom_range(8'hF8, 8'hFF));
    endfunction

    initial begin
        clock      = 0;
        reset      = 1;
        byte_valid = 0;
        byte_data  = 0;
        msg_ready  = 0;
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        @(negedge clock);
        check("rst_valid0", 32'(v0), 32'd0);
        check("rst_status0", 32'(s0), 32'd0);
        check("rst_data1_0", 32'(a0), 32'd0);
        check("rst_data2_0", 32'(b0), 32'd0);
        check("rst_drop0", 32'(dc0), 32'd0);
        check("rst_valid1", 32'(v1), 32'd0);

        // Data without status is discarded.
        send(8'h3C, 1'b1); send(8'h40, 1'b1); idle(3, 1'b1);

        // Running status plus velocity-0 note-on.
        send(8'h90, 1'b1); send(8'h3C, 1'b1); send(8'h64, 1'b1);
        send(8'h40, 1'b1); send(8'h00, 1'b1); idle(3, 1'b1);

        // Real-time interleave, one-byte messages, aborted partial message.
        send(8'hB2, 1'b1); send(8'h07, 1'b1); send(8'hF8, 1'b1); send(8'h55, 1'b1);
        send(8'hC5, 1'b1); send(8'h0A, 1'b1); send(8'h0B, 1'b1);
        send(8'h91, 1'b1); send(8'h3C, 1'b1); send(8'hE3, 1'b1); send(8'h00, 1'b1);
        send(8'h40, 1'b1); idle(3, 1'b1);

        // Backpressure: three completions, first held, two dropped.
        send(8'h90, 1'b0);
        for (int i = 0; i < 3; i++) begin
            send(8'h3C, 1'b0);
            send(8'(8'h64 + i), 1'b0);
        end
        idle(4, 1'b0);
        @(negedge clock);
        check("bp_drop", 32'(dc0), 32'd2);
        idle(1, 1'b1);
        idle(3, 1'b0);

        // SysEx is skipped; filter instance only passes channel 3.
        send(8'hF0, 1'b1); send(8'h7E, 1'b1); send(8'h01, 1'b1); send(8'hF7, 1'b1);
        send(8'h45, 1'b1);
        send(8'h92, 1'b1); send(8'h3C, 1'b1); send(8'h64, 1'b1);
        send(8'h93, 1'b1); send(8'h3C, 1'b1); send(8'h64, 1'b1); idle(3, 1'b1);

        // Saturation of drop_count.
        send(8'h90, 1'b0);
        for (int i = 0; i < 302; i++) begin
            send(8'h3C, 1'b0);
            send(8'h64, 1'b0);
        end
        idle(2, 1'b0);
        @(negedge clock);
        check("sat_drop", 32'(dc0), 32'd255);

        // Reset between status and data kills the partial message and the counter.
        send(8'h90, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        send(8'h3C, 1'b1); send(8'h64, 1'b1); idle(3, 1'b1);
        @(negedge clock);
        check("rst_mid_drop", 32'(dc0), 32'd0);
        check("rst_mid_valid", 32'(v0), 32'd0);

        // Randomized traffic with random backpressure and rare resets.
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 999) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                 rand_byte(),
                 ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
        end
        idle(6, 1'b1);
        @(negedge clock);
        #1;
        check("drain0", 32'(q0.size()), 32'd0);
        check("drain1", 32'(q1.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
